multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Multi-cycle sequencer for the RV32I datapath.
- Owns the program counter and fetches from instruction memory through a req/valid handshake, then latches the instruction register.
- Classifies the opcode and steps through FETCH/DECODE/EXECUTE/MEM/WB, driving register-file write enable, data-memory strobes and PC update.
- Replaces the free-running PC incrementer; sits between instruction/data memories and the register file/ALU.

Parameters:
- WORD_WIDTH, 32, width of PC, addresses and data.
- RESET_PC, 0, PC value loaded on reset.
- PC_INC, 1, sequential PC step (word-addressed memory).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- o_imem_req  out  1  fetch request, held until i_imem_valid.
- o_imem_addr  out  WORD_WIDTH  fetch address, equals o_pc.
- i_imem_valid  in  1  fetch data valid; may be asserted in the same cycle as req.
- i_imem_data  in  32  fetched instruction.
- o_ir  out  32  latched instruction register.
- o_pc  out  WORD_WIDTH  current PC.
- i_alu_result  in  WORD_WIDTH  ALU output; unused by this block except via datapath muxing.
- i_branch_taken  in  1  branch compare result, sampled in EXECUTE.
- i_target  in  WORD_WIDTH  branch/jump target computed by datapath.
- o_dmem_req  out  1  data access request, held until i_dmem_valid.
- o_dmem_we  out  1  store qualifier for o_dmem_req.
- i_dmem_valid  in  1  data access complete.
- o_rf_wen  out  1  register-file write strobe, one-cycle pulse.
- o_wd_sel  out  2  write-data source: 0 ALU, 1 MEM, 2 PC+PC_INC.
- o_state  out  3  current FSM state (debug).
- o_illegal  out  1  sticky illegal-opcode flag.
- o_retired  out  32  retired-instruction count (see Optional Feature).

Behaviour:
- Reset (async, immediate) values:
  - o_pc = RESET_PC, o_ir = 0, state = FETCH.
  - o_imem_req, o_dmem_req, o_dmem_we, o_rf_wen, o_illegal = 0; o_wd_sel = 0; o_retired = 0.
  - A reset mid-transaction drops any outstanding request with no completion.
  - Fetch starts on the first rising edge after deassertion.
- States and transitions:
  - FETCH: o_imem_req = 1. On i_imem_valid, IR <= i_imem_data and go to DECODE; otherwise stay.
  - DECODE: 1 cycle; classify IR[6:0].
    - Class R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
    - Any other opcode goes to TRAP; o_illegal <= 1.
  - EXECUTE: 1 cycle.
    - BRANCH: pc <= i_branch_taken ? i_target : pc+PC_INC; retire; go to FETCH.
    - LOAD/STORE: go to MEM.
    - Others: go to WB.
  - MEM: o_dmem_req = 1, o_dmem_we = (STORE), held until i_dmem_valid.
    - STORE: pc <= pc+PC_INC; retire; go to FETCH.
    - LOAD: go to WB.
  - WB: o_rf_wen = (IR[11:7] != 0) for exactly this cycle; o_wd_sel per class.
    - LOAD selects MEM; JAL/JALR select PC+PC_INC; others select ALU.
    - pc <= (JAL/JALR) ? i_target : pc+PC_INC; retire; go to FETCH.
  - TRAP: terminal; no requests, no writes, PC frozen; exit only via reset.
- Outputs: all outputs are registered or decoded from state/IR only. i_imem_data feeds IR only; o_ir changes only on the FETCH completion edge.
- Latency with zero-wait memories (valid in the same cycle as req):
  - ALU/jump instruction: 4 cycles. Branch: 3. Store: 4. Load: 5.
  - Each wait cycle adds 1.
- PC arithmetic is modulo 2^WORD_WIDTH; wrap from all-ones to 0 is silent.
- i_imem_valid outside FETCH and i_dmem_valid outside MEM are ignored.

Optional Feature:
- Macro RETIRE_CNT_EN.
- Defined: o_retired increments by 1 on each retire event (branch/store/WB completion), modulo 2^32; it does not count in TRAP.
- Undefined: counter logic is absent and o_retired is tied to 0.

Decomposition:
- Shared definitions header/package:
  - opcode constants;
  - FSM state encodings (FETCH 0, DECODE 1, EXECUTE 2, MEM 3, WB 4, TRAP 7);
  - o_wd_sel encodings.
- One combinational sub-module, instr_class_decoder: opcode to class one-hot plus an illegal bit. Used in DECODE and reused later by the datapath.

Test Plan:
- Reset, then IR = 0x00500093 (ADDI x1,x0,5), zero-wait memory -> o_rf_wen pulses in cycle 4 with o_wd_sel = 0; o_pc goes 0 -> 1.
- NOP 0x00000013 -> full FETCH..WB sequence with o_rf_wen never asserted (rd = x0); o_pc advances by 1.
- BEQ 0x00000463 with i_branch_taken = 1, i_target = 0x10 -> o_pc = 0x10 after EXECUTE; no o_rf_wen, no o_dmem_req; with taken = 0 -> o_pc = old+1.
- LW 0x00002103 with i_dmem_valid delayed 3 cycles -> o_dmem_req held 4 cycles, o_dmem_we = 0; then WB with o_rf_wen = 1, o_wd_sel = 1; total 8 cycles.
- 0xFFFFFFFF -> o_illegal = 1 after DECODE, o_state = 7; no further o_imem_req for 20 cycles; i_rst_n low clears o_illegal, o_pc = 0.
- i_rst_n asserted mid-MEM of SW 0x00202023 -> o_dmem_req drops in the same cycle without a clock edge; next fetch from RESET_PC; o_retired (with RETIRE_CNT_EN) = 0.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle RV32I sequencer: opcodes, FSM state
// encodings, write-data select codes and instruction-class bit positions.
package multicycle_control_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_TRAP    = 3'd7
  } state_t;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MEM = 2'd1;
  localparam logic [1:0] WD_PC  = 2'd2;

  // Bit positions inside the one-hot class vector.
  localparam int C_R      = 0;
  localparam int C_IALU   = 1;
  localparam int C_LOAD   = 2;
  localparam int C_STORE  = 3;
  localparam int C_BRANCH = 4;
  localparam int C_JAL    = 5;
  localparam int C_JALR   = 6;
  localparam int C_LUI    = 7;
  localparam int C_AUIPC  = 8;
  localparam int CLS_W    = 9;

endpackage

// File: rtl/instr_class_decoder.sv
// Combinational opcode classifier: one-hot instruction class plus an illegal
// flag for any opcode outside the supported RV32I set.
module instr_class_decoder
  import multicycle_control_pkg::*;
(
  input  logic [6:0]       i_opcode,
  output logic [CLS_W-1:0] o_cls,
  output logic             o_illegal
);

  always_comb begin
    o_cls     = '0;
    o_illegal = 1'b0;
    case (i_opcode)
      OP_R:      o_cls[C_R]      = 1'b1;
      OP_IALU:   o_cls[C_IALU]   = 1'b1;
      OP_LOAD:   o_cls[C_LOAD]   = 1'b1;
      OP_STORE:  o_cls[C_STORE]  = 1'b1;
      OP_BRANCH: o_cls[C_BRANCH] = 1'b1;
      OP_JAL:    o_cls[C_JAL]    = 1'b1;
      OP_JALR:   o_cls[C_JALR]   = 1'b1;
      OP_LUI:    o_cls[C_LUI]    = 1'b1;
      OP_AUIPC:  o_cls[C_AUIPC]  = 1'b1;
      default:   o_illegal       = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I sequencer: owns the PC, fetches over req/valid, steps
// FETCH/DECODE/EXECUTE/MEM/WB. Optional retire counter under RETIRE_CNT_EN.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int                    WORD_WIDTH = 32,
  parameter logic [WORD_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [WORD_WIDTH-1:0] PC_INC     = {{(WORD_WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  output logic                  o_imem_req,
  output logic [WORD_WIDTH-1:0] o_imem_addr,
  input  logic                  i_imem_valid,
  input  logic [31:0]           i_imem_data,
  output logic [31:0]           o_ir,
  output logic [WORD_WIDTH-1:0] o_pc,
  input  logic [WORD_WIDTH-1:0] i_alu_result,
  input  logic                  i_branch_taken,
  input  logic [WORD_WIDTH-1:0] i_target,
  output logic                  o_dmem_req,
  output logic                  o_dmem_we,
  input  logic                  i_dmem_valid,
  output logic                  o_rf_wen,
  output logic [1:0]            o_wd_sel,
  output logic [2:0]            o_state,
  output logic                  o_illegal,
  output logic [31:0]           o_retired
);

  // Handshake: a request is raised by a registered output and held until the
  // matching valid is seen high on a rising edge; valid is ignored otherwise.
  state_t                r_state;
  logic [WORD_WIDTH-1:0] r_pc;
  logic [31:0]           r_ir;
  logic                  r_imem_req;
  logic                  r_dmem_req;
  logic                  r_dmem_we;
  logic                  r_rf_wen;
  logic [1:0]            r_wd_sel;
  logic                  r_illegal;

  logic [CLS_W-1:0]      w_cls;
  logic                  w_illegal;
  logic [WORD_WIDTH-1:0] w_pc_next;
  logic                  w_rd_nz;
  logic                  w_jump;
  logic                  w_unused;

  instr_class_decoder u_dec (
    .i_opcode  (r_ir[6:0]),
    .o_cls     (w_cls),
    .o_illegal (w_illegal)
  );

  assign w_pc_next = r_pc + PC_INC;
  assign w_rd_nz   = (r_ir[11:7] != 5'd0);
  assign w_jump    = w_cls[C_JAL] | w_cls[C_JALR];
  assign w_unused  = ^{i_alu_result, w_cls};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_FETCH;
      r_pc       <= RESET_PC;
      r_ir       <= '0;
      r_imem_req <= 1'b0;
      r_dmem_req <= 1'b0;
      r_dmem_we  <= 1'b0;
      r_rf_wen   <= 1'b0;
      r_wd_sel   <= WD_ALU;
      r_illegal  <= 1'b0;
    end else begin
      r_rf_wen <= 1'b0;
      case (r_state)
        S_FETCH: begin
          // The first FETCH cycle after reset only raises the request.
          if (!r_imem_req) begin
            r_imem_req <= 1'b1;
          end else if (i_imem_valid) begin
            r_ir       <= i_imem_data;
            r_imem_req <= 1'b0;
            r_state    <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (w_illegal) begin
            r_illegal <= 1'b1;
            r_state   <= S_TRAP;
          end else begin
            r_state <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          if (w_cls[C_BRANCH]) begin
            r_pc       <= i_branch_taken ? i_target : w_pc_next;
            r_imem_req <= 1'b1;
            r_state    <= S_FETCH;
          end else if (w_cls[C_LOAD] | w_cls[C_STORE]) begin
            r_dmem_req <= 1'b1;
            r_dmem_we  <= w_cls[C_STORE];
            r_state    <= S_MEM;
          end else begin
            r_rf_wen <= w_rd_nz;
            r_wd_sel <= w_jump ? WD_PC : WD_ALU;
            r_state  <= S_WB;
          end
        end
        S_MEM: begin
          if (i_dmem_valid) begin
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            if (w_cls[C_STORE]) begin
              r_pc       <= w_pc_next;
              r_imem_req <= 1'b1;
              r_state    <= S_FETCH;
            end else begin
              r_rf_wen <= w_rd_nz;
              r_wd_sel <= WD_MEM;
              r_state  <= S_WB;
            end
          end
        end
        S_WB: begin
          r_pc       <= w_jump ? i_target : w_pc_next;
          r_imem_req <= 1'b1;
          r_state    <= S_FETCH;
        end
        S_TRAP: begin
        end
        default: r_state <= S_TRAP;
      endcase
    end
  end

`ifdef RETIRE_CNT_EN
  logic [31:0] r_retired;
  logic        w_retire;

  assign w_retire = ((r_state == S_EXECUTE) && w_cls[C_BRANCH])
                  | ((r_state == S_MEM) && i_dmem_valid && w_cls[C_STORE])
                  | (r_state == S_WB);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      r_retired <= '0;
    else if (w_retire) r_retired <= r_retired + 32'd1;
  end

  assign o_retired = r_retired;
`else
  assign o_retired = '0;
`endif

  assign o_imem_req  = r_imem_req;
  assign o_imem_addr = r_pc;
  assign o_pc        = r_pc;
  assign o_ir        = r_ir;
  assign o_dmem_req  = r_dmem_req;
  assign o_dmem_we   = r_dmem_we;
  assign o_rf_wen    = r_rf_wen;
  assign o_wd_sel    = r_wd_sel;
  assign o_state     = r_state;
  assign o_illegal   = r_illegal;

endmodule
